// File: rtl/sb_crc_pkg.sv
// rtl/sb_crc_pkg.sv - shared constants, tx state enum and CRC-16 bit step for the sideband link
package sb_crc_pkg;

   localparam logic [15:0] CRC16_POLY = 16'h8005;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;
   localparam int          SYM_BITS   = 10;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_DATA,
      TX_GAP,
      TX_CRC_HI,
      TX_CRC_LO,
      TX_DONE
   } tx_state_t;

   // One serial bit into an MSB-feedback CRC register.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                              input logic        bit_in,
                                              input logic [15:0] poly = CRC16_POLY);
      logic fb;
      fb = crc[15] ^ bit_in;
      return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
   endfunction

endpackage

// File: rtl/sb_sym_ser.sv
// rtl/sb_sym_ser.sv - 10-bit symbol framer: start 0, eight data bits, stop 1
module sb_sym_ser
   import sb_crc_pkg::*;
(
   input  logic       sb_clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_data,
   input  logic       msb_first,
   input  logic       run,
   output logic [3:0] cnt,
   output logic       ser
);

   localparam logic [3:0] LAST_CNT = 4'(SYM_BITS - 1);

   logic [7:0] shreg;
   logic [7:0] sh_nxt;
   logic       msb_q;

   // The register only shifts once the first data bit is on the line.
   always_comb begin
      sh_nxt = shreg;
      if (cnt != 4'd0)
         sh_nxt = msb_q ? {shreg[6:0], 1'b0} : {1'b0, shreg[7:1]};
   end

   // Line value is registered for the bit position being entered.
   always_ff @(posedge sb_clk) begin
      if (rst) begin
         cnt   <= 4'd0;
         shreg <= 8'h00;
         msb_q <= 1'b0;
         ser   <= 1'b1;
      end else if (load) begin
         cnt   <= 4'd0;
         shreg <= load_data;
         msb_q <= msb_first;
         ser   <= 1'b0;
      end else if (run && cnt != LAST_CNT) begin
         cnt   <= cnt + 4'd1;
         shreg <= sh_nxt;
         ser   <= (cnt == LAST_CNT - 4'd1) ? 1'b1 : (msb_q ? sh_nxt[7] : sh_nxt[0]);
      end else begin
         cnt   <= 4'd0;
         ser   <= 1'b1;
      end
   end

endmodule

// File: rtl/crc_16_trans.sv
// rtl/crc_16_trans.sv - sideband tx CRC-16 generator and byte serializer
module crc_16_trans
   import sb_crc_pkg::*;
#(
   parameter logic [15:0] POLY = CRC16_POLY,
   parameter logic [15:0] INIT = CRC16_INIT
) (
   input  logic       sb_clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   input  logic       data_last,
   output logic       data_ready,
   output logic       trans_ser,
   output logic       crc_en,
   output logic       busy,
   output logic       done
);

   localparam logic [3:0] LAST_CNT = 4'(SYM_BITS - 1);

   tx_state_t   state;
   tx_state_t   state_nxt;
   logic [15:0] crc;
   logic [15:0] crc_q;
   logic        last_q;
   logic        ready_q;
   logic [3:0]  cnt;
   logic        accept;
   logic        sym_end;
   logic        run;
   logic        ld;
   logic        ld_msb;
   logic [7:0]  ld_data;

   assign data_ready = ready_q;
   assign accept     = data_valid && ready_q;
   assign sym_end    = (cnt == LAST_CNT);
   assign run        = (state == TX_DATA) || (state == TX_CRC_HI) || (state == TX_CRC_LO);

   // Next state; an accept in DATA can only happen on the stop bit of a non-last byte.
   always_comb begin
      state_nxt = state;
      case (state)
         TX_IDLE, TX_GAP: if (accept) state_nxt = TX_DATA;
         TX_DATA: begin
            if (sym_end) begin
               if (accept)      state_nxt = TX_DATA;
               else if (last_q) state_nxt = TX_CRC_HI;
               else             state_nxt = TX_GAP;
            end
         end
         TX_CRC_HI: if (sym_end) state_nxt = TX_CRC_LO;
         TX_CRC_LO: if (sym_end) state_nxt = TX_DONE;
         TX_DONE:   state_nxt = TX_IDLE;
         default:   state_nxt = TX_IDLE;
      endcase
   end

   // Symbol loads: payload LSB first, CRC halves MSB first straight after the last byte.
   always_comb begin
      ld      = 1'b0;
      ld_data = data_in;
      ld_msb  = 1'b0;
      if (accept) begin
         ld = 1'b1;
      end else if (state == TX_DATA && sym_end && last_q) begin
         ld      = 1'b1;
         ld_data = crc[15:8];
         ld_msb  = 1'b1;
      end else if (state == TX_CRC_HI && sym_end) begin
         ld      = 1'b1;
         ld_data = crc_q[7:0];
         ld_msb  = 1'b1;
      end
   end

   sb_sym_ser u_ser (
      .sb_clk    (sb_clk),
      .rst       (rst),
      .load      (ld),
      .load_data (ld_data),
      .msb_first (ld_msb),
      .run       (run),
      .cnt       (cnt),
      .ser       (trans_ser)
   );

   // FSM, CRC accumulation and registered status outputs.
   always_ff @(posedge sb_clk) begin
      if (rst) begin
         state   <= TX_IDLE;
         crc     <= INIT;
         crc_q   <= INIT;
         last_q  <= 1'b0;
         ready_q <= 1'b0;
         crc_en  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         ready_q <= (state_nxt == TX_IDLE) || (state_nxt == TX_GAP) ||
                    (state == TX_DATA && cnt == LAST_CNT - 4'd1 && !last_q);
         crc_en  <= (state_nxt == TX_DATA) || (state_nxt == TX_CRC_HI) ||
                    (state_nxt == TX_CRC_LO);
         done    <= (state_nxt == TX_DONE);
         if (accept) begin
            last_q <= data_last;
            busy   <= 1'b1;
         end else if (state == TX_DONE) begin
            busy   <= 1'b0;
         end
         if (state == TX_DATA && cnt >= 4'd1 && cnt <= 4'd8)
            crc <= crc16_step(crc, trans_ser, POLY);
         else if (state == TX_DONE)
            crc <= INIT;
         if (state == TX_DATA && sym_end && last_q)
            crc_q <= crc;
      end
   end

endmodule

// File: tb/tb_crc_16_trans.sv
// tb/tb_crc_16_trans.sv - directed vector bench for crc_16_trans
module tb_crc_16_trans;
   import sb_crc_pkg::*;

   logic       sb_clk;
   logic       rst;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_last;
   logic       data_ready;
   logic       trans_ser;
   logic       crc_en;
   logic       busy;
   logic       done;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic ser_log   [0:4095];
   logic en_log    [0:4095];
   logic ready_log [0:4095];

   typedef struct {
      string       name;
      int          n;
      logic [31:0] bytes;
      int          gap;
      logic [15:0] exp_crc;
      int          exp_lat;
   } vec_t;

   vec_t vecs [4];

   crc_16_trans dut (
      .sb_clk     (sb_clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_last  (data_last),
      .data_ready (data_ready),
      .trans_ser  (trans_ser),
      .crc_en     (crc_en),
      .busy       (busy),
      .done       (done)
   );

   initial sb_clk = 1'b0;
   always #5 sb_clk = ~sb_clk;

   always @(posedge sb_clk) begin
      #2;
      if (cyc < 4096) begin
         ser_log[cyc]   = trans_ser;
         en_log[cyc]    = crc_en;
         ready_log[cyc] = data_ready;
      end
      cyc++;
   end

   task automatic check_int(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] crc_model(input logic [31:0] bytes, input int n);
      logic [15:0] c;
      c = CRC16_INIT;
      for (int i = 0; i < n; i++)
         for (int k = 0; k < 8; k++)
            c = crc16_step(c, bytes[8*i+k]);
      return c;
   endfunction

   task automatic wait_ready();
      int w;
      w = 0;
      while (!data_ready && w < 60) begin
         @(negedge sb_clk);
         w++;
      end
      check_int("ready timeout", {31'd0, data_ready}, 32'd1);
   endtask

   task automatic wait_done(output int td);
      int w;
      w = 0;
      while (!done && w < 120) begin
         @(negedge sb_clk);
         w++;
      end
      check_int("done timeout", {31'd0, done}, 32'd1);
      td = cyc - 1;
   endtask

   task automatic send_pkt(input logic [31:0] bytes, input int n, input int gap,
                           input bit hold, input logic [7:0] follow,
                           output int ta, output int td);
      ta = 0;
      for (int i = 0; i < n; i++) begin
         data_in    = bytes[8*i +: 8];
         data_last  = (i == n - 1);
         data_valid = 1'b1;
         if (i == 1 && gap > 0) begin
            data_valid = 1'b0;
            wait_ready();
            repeat (gap) @(negedge sb_clk);
            data_valid = 1'b1;
         end
         wait_ready();
         if (i == 0) ta = cyc - 1;
         @(negedge sb_clk);
      end
      if (hold) begin
         data_in    = follow;
         data_last  = 1'b1;
         data_valid = 1'b1;
      end else begin
         data_valid = 1'b0;
      end
      wait_done(td);
   endtask

   task automatic check_packet(input string nm, input int ta, input int td,
                               input logic [31:0] bytes, input int n, input int gap,
                               input logic [15:0] exp_crc, input int exp_lat);
      logic        bits[$];
      int          nz, ferr, derr;
      logic [15:0] got, res;
      bits = {};
      nz   = 0;
      ferr = 0;
      derr = 0;
      got  = 16'h0000;
      res  = CRC16_INIT;
      for (int c = ta + 1; c < td && c < 4096; c++) begin
         if (en_log[c]) bits.push_back(ser_log[c]);
         else if (ser_log[c]) nz++;
      end
      check_int({nm, " latency"}, td - ta, exp_lat);
      check_int({nm, " bit count"}, bits.size(), 10 * (n + 2));
      check_int({nm, " idle gap cycles"}, nz, gap);
      if (bits.size() == 10 * (n + 2)) begin
         for (int s = 0; s < n + 2; s++)
            if (bits[10*s] !== 1'b0 || bits[10*s+9] !== 1'b1) ferr++;
         for (int i = 0; i < n; i++)
            for (int k = 0; k < 8; k++)
               if (bits[10*i+1+k] !== bytes[8*i+k]) derr++;
         for (int k = 0; k < 8; k++) begin
            got[15-k] = bits[10*n+1+k];
            got[7-k]  = bits[10*(n+1)+1+k];
         end
         for (int s = 0; s < n + 2; s++)
            for (int k = 1; k <= 8; k++)
               res = crc16_step(res, bits[10*s+k]);
         check_int({nm, " framing errors"}, ferr, 0);
         check_int({nm, " data bit errors"}, derr, 0);
         check_int({nm, " crc"}, got, exp_crc);
         check_int({nm, " residual"}, res, 16'h0000);
      end
   endtask

   initial begin
      int ta, td, ta2, td2, rdy, ser_hi;

      vecs[0] = '{"p00",    1, 32'h0000_0000, 0, 16'hFD02, 31};
      vecs[1] = '{"pA53C",  2, 32'h0000_3CA5, 0, 16'h0000, 41};
      vecs[2] = '{"p1122g", 2, 32'h0000_2211, 5, 16'h0000, 46};
      vecs[3] = '{"p3byte", 3, 32'h0080_00FF, 2, 16'h0000, 53};
      for (int i = 1; i < 4; i++) vecs[i].exp_crc = crc_model(vecs[i].bytes, vecs[i].n);

      rst        = 1'b1;
      data_in    = 8'h00;
      data_valid = 1'b0;
      data_last  = 1'b0;
      repeat (3) @(negedge sb_clk);
      check_int("rst trans_ser", trans_ser, 1);
      check_int("rst crc_en", crc_en, 0);
      check_int("rst data_ready", data_ready, 0);
      check_int("rst busy", busy, 0);
      check_int("rst done", done, 0);
      rst = 1'b0;

      ser_hi = 0;
      repeat (20) begin
         @(negedge sb_clk);
         if (trans_ser) ser_hi++;
      end
      check_int("idle line high", ser_hi, 20);
      check_int("idle crc_en", crc_en, 0);
      check_int("idle data_ready", data_ready, 1);
      check_int("idle busy", busy, 0);
      check_int("idle done", done, 0);

      for (int v = 0; v < 4; v++) begin
         send_pkt(vecs[v].bytes, vecs[v].n, vecs[v].gap, 1'b0, 8'h00, ta, td);
         check_packet(vecs[v].name, ta, td, vecs[v].bytes, vecs[v].n, vecs[v].gap,
                      vecs[v].exp_crc, vecs[v].exp_lat);
         repeat (3) @(negedge sb_clk);
      end

      // Reset in the middle of the CRC high symbol.
      data_in    = 8'h00;
      data_last  = 1'b1;
      data_valid = 1'b1;
      wait_ready();
      ta = cyc - 1;
      @(negedge sb_clk);
      data_valid = 1'b0;
      repeat (14) @(negedge sb_clk);
      check_int("pre-reset crc_en", crc_en, 1);
      rst = 1'b1;
      @(negedge sb_clk);
      check_int("abort trans_ser", trans_ser, 1);
      check_int("abort crc_en", crc_en, 0);
      check_int("abort busy", busy, 0);
      check_int("abort data_ready", data_ready, 0);
      @(negedge sb_clk);
      rst = 1'b0;
      repeat (2) @(negedge sb_clk);
      check_int("post-reset ready", data_ready, 1);
      send_pkt(32'h0, 1, 0, 1'b0, 8'h00, ta, td);
      check_packet("post-reset p00", ta, td, 32'h0, 1, 0, 16'hFD02, 31);
      repeat (3) @(negedge sb_clk);

      // Valid held through CRC and DONE.
      send_pkt(32'h0, 1, 0, 1'b1, 8'h5A, ta, td);
      check_packet("hold first", ta, td, 32'h0, 1, 0, 16'hFD02, 31);
      rdy = 0;
      for (int c = ta + 1; c <= td && c < 4096; c++) if (ready_log[c]) rdy++;
      check_int("hold ready while busy", rdy, 0);
      @(negedge sb_clk);
      check_int("hold ready after done", data_ready, 1);
      ta2 = cyc - 1;
      check_int("hold accept cycle", ta2 - td, 1);
      @(negedge sb_clk);
      data_valid = 1'b0;
      check_int("hold start bit", {31'd0, ser_log[td+2]}, 0);
      check_int("hold start crc_en", {31'd0, en_log[td+2]}, 1);
      wait_done(td2);
      check_packet("hold second", ta2, td2, 32'h5A, 1, 0, crc_model(32'h5A, 1), 31);

      repeat (3) @(negedge sb_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
